// File: rtl/mips_defs.sv
// Shared MIPS opcode/funct constants plus the multi-cycle control encodings.
package mips_defs;

    localparam logic [5:0] OPCODE_SPECIAL = 6'b000000;
    localparam logic [5:0] OPCODE_J       = 6'b000010;
    localparam logic [5:0] OPCODE_JAL     = 6'b000011;
    localparam logic [5:0] OPCODE_BEQ     = 6'b000100;
    localparam logic [5:0] OPCODE_ADDI    = 6'b001000;
    localparam logic [5:0] OPCODE_ADDIU   = 6'b001001;
    localparam logic [5:0] OPCODE_ORI     = 6'b001101;
    localparam logic [5:0] OPCODE_LUI     = 6'b001111;
    localparam logic [5:0] OPCODE_LB      = 6'b100000;
    localparam logic [5:0] OPCODE_LW      = 6'b100011;
    localparam logic [5:0] OPCODE_SB      = 6'b101000;
    localparam logic [5:0] OPCODE_SW      = 6'b101011;
    localparam logic [5:0] OPCODE_HLT     = 6'b111111;

    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_RS     = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [2:0] ALUOP_ADD = 3'd0;
    localparam logic [2:0] ALUOP_SUB = 3'd1;
    localparam logic [2:0] ALUOP_OR  = 3'd2;
    localparam logic [2:0] ALUOP_SLT = 3'd3;
    localparam logic [2:0] ALUOP_LUI = 3'd4;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_UPPER = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_HALT     = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_J       = 4'd1,
        CLS_JAL     = 4'd2,
        CLS_JR      = 4'd3,
        CLS_BEQ     = 4'd4,
        CLS_HALT    = 4'd5,
        CLS_RTYPE   = 4'd6,
        CLS_IALU    = 4'd7,
        CLS_LOAD    = 4'd8,
        CLS_STORE   = 4'd9
    } inst_cls_t;

    typedef struct packed {
        inst_cls_t  cls;
        logic [2:0] alu_op;
        logic [1:0] ext_op;
        logic       is_byte;
        logic       is_addi;
    } dec_t;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: opcode/funct to class and ALU/extend controls.
module mips_mc_decode
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec_c
);

    always_comb begin
        dec_c         = '0;
        dec_c.cls     = CLS_ILLEGAL;
        dec_c.alu_op  = ALUOP_ADD;
        dec_c.ext_op  = EXT_SIGN;
        case (opcode)
            OPCODE_SPECIAL: begin
                case (funct)
                    FUNCT_JR:   dec_c.cls = CLS_JR;
                    FUNCT_ADDU: dec_c.cls = CLS_RTYPE;
                    FUNCT_SUBU: begin
                        dec_c.cls    = CLS_RTYPE;
                        dec_c.alu_op = ALUOP_SUB;
                    end
                    FUNCT_SLT: begin
                        dec_c.cls    = CLS_RTYPE;
                        dec_c.alu_op = ALUOP_SLT;
                    end
                    default: dec_c.cls = CLS_ILLEGAL;
                endcase
            end
            OPCODE_J:   dec_c.cls = CLS_J;
            OPCODE_JAL: dec_c.cls = CLS_JAL;
            OPCODE_BEQ: begin
                dec_c.cls    = CLS_BEQ;
                dec_c.alu_op = ALUOP_SUB;
            end
            OPCODE_ADDI: begin
                dec_c.cls     = CLS_IALU;
                dec_c.is_addi = 1'b1;
            end
            OPCODE_ADDIU: dec_c.cls = CLS_IALU;
            OPCODE_ORI: begin
                dec_c.cls    = CLS_IALU;
                dec_c.alu_op = ALUOP_OR;
                dec_c.ext_op = EXT_ZERO;
            end
            OPCODE_LUI: begin
                dec_c.cls    = CLS_IALU;
                dec_c.alu_op = ALUOP_LUI;
                dec_c.ext_op = EXT_UPPER;
            end
            OPCODE_LW: dec_c.cls = CLS_LOAD;
            OPCODE_LB: begin
                dec_c.cls     = CLS_LOAD;
                dec_c.is_byte = 1'b1;
            end
            OPCODE_SW: dec_c.cls = CLS_STORE;
            OPCODE_SB: begin
                dec_c.cls     = CLS_STORE;
                dec_c.is_byte = 1'b1;
            end
            OPCODE_HLT: dec_c.cls = CLS_HALT;
            default:    dec_c.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with a ready/request data-memory handshake.
module mips_mc_ctrl
    import mips_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       ir_write_en,
    output logic       pc_write_en,
    output logic [1:0] npc_sel,
    output logic       reg_write_en,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] ext_op,
    output logic       mem_req,
    output logic       mem_write_en,
    output logic       mem_byte,
    output logic       halt_sig,
    output logic       illegal_inst,
    output logic       mem_err,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             timeout_c;
    dec_t             dec_c;

    mips_mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec_c  (dec_c)
    );

    // The wait that is about to elapse is the last one allowed.
    assign timeout_c = (MEM_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == MEM_TIMEOUT);

    assign state   = state_q;
    assign mem_err = mem_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next state and datapath controls; everything is forced low while reset is high.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        mem_err_d    = mem_err_q;
        ir_write_en  = 1'b0;
        pc_write_en  = 1'b0;
        npc_sel      = NPC_PC4;
        reg_write_en = 1'b0;
        reg_dst      = REGDST_RT;
        wb_sel       = WB_ALU;
        alu_src_b    = 1'b0;
        alu_op       = ALUOP_ADD;
        ext_op       = EXT_ZERO;
        mem_req      = 1'b0;
        mem_write_en = 1'b0;
        mem_byte     = 1'b0;
        halt_sig     = 1'b0;
        illegal_inst = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_write_en = 1'b1;
                    pc_write_en = 1'b1;
                    npc_sel     = NPC_PC4;
                    state_d     = S_DECODE;
                end
                S_DECODE: begin
                    alu_op  = dec_c.alu_op;
                    ext_op  = dec_c.ext_op;
                    state_d = S_FETCH;
                    case (dec_c.cls)
                        CLS_J: begin
                            pc_write_en = 1'b1;
                            npc_sel     = NPC_JUMP;
                        end
                        CLS_JAL: begin
                            pc_write_en  = 1'b1;
                            npc_sel      = NPC_JUMP;
                            reg_write_en = 1'b1;
                            reg_dst      = REGDST_RA;
                            wb_sel       = WB_PC;
                        end
                        CLS_JR: begin
                            pc_write_en = 1'b1;
                            npc_sel     = NPC_RS;
                        end
                        CLS_BEQ: begin
                            pc_write_en = zero;
                            npc_sel     = zero ? NPC_BRANCH : NPC_PC4;
                        end
                        CLS_HALT:  state_d = S_HALT;
                        CLS_RTYPE: state_d = S_EXEC_R;
                        CLS_IALU:  state_d = S_EXEC_I;
                        CLS_LOAD,
                        CLS_STORE: state_d = S_MEM_ADDR;
                        default:   illegal_inst = 1'b1;
                    endcase
                end
                S_EXEC_R: begin
                    alu_op    = dec_c.alu_op;
                    ext_op    = dec_c.ext_op;
                    alu_src_b = 1'b0;
                    state_d   = S_WB_ALU;
                end
                S_EXEC_I: begin
                    alu_op    = dec_c.alu_op;
                    ext_op    = dec_c.ext_op;
                    alu_src_b = 1'b1;
                    state_d   = S_WB_ALU;
                end
                S_WB_ALU: begin
                    alu_op       = dec_c.alu_op;
                    ext_op       = dec_c.ext_op;
                    alu_src_b    = (dec_c.cls != CLS_RTYPE);
                    reg_write_en = !(dec_c.is_addi && overflow);
                    wb_sel       = WB_ALU;
                    reg_dst      = (dec_c.cls == CLS_RTYPE) ? REGDST_RD : REGDST_RT;
                    state_d      = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_op    = ALUOP_ADD;
                    ext_op    = EXT_SIGN;
                    alu_src_b = 1'b1;
                    state_d   = (dec_c.cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD,
                S_MEM_WR: begin
                    alu_op       = ALUOP_ADD;
                    ext_op       = EXT_SIGN;
                    alu_src_b    = 1'b1;
                    mem_req      = 1'b1;
                    mem_write_en = (state_q == S_MEM_WR);
                    mem_byte     = dec_c.is_byte;
                    if (mem_ready) begin
                        state_d = (state_q == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                    end else if (timeout_c) begin
                        mem_err_d = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WB_MEM: begin
                    reg_write_en = 1'b1;
                    wb_sel       = WB_MEM;
                    reg_dst      = REGDST_RT;
                    state_d      = S_FETCH;
                end
                S_HALT: begin
                    halt_sig = 1'b1;
                    state_d  = S_HALT;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core. Sequences the shared datapath (ifu, gpr, ALU, data memory) through FETCH/DECODE/EXEC/MEM/WB steps, one instruction at a time.
- Replaces per-instruction single-cycle control.
- Adds a ready/request handshake to data memory so slow memories stall the core.
- Drives halt_sig, which the bench watches to finish.

Parameters:
- MEM_TIMEOUT, 0, cycles to wait on mem_ready before flagging mem_err. 0 = wait forever.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  6  IR[31:26] of latched instruction
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- overflow  in  1  ALU signed overflow
- mem_ready  in  1  data memory access complete this cycle
- ir_write_en  out  1  latch instruction register
- pc_write_en  out  1  update PC from npc mux
- npc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr)
- reg_write_en  out  1  GPR write strobe
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
- wb_sel  out  2  0 = ALU, 1 = mem, 2 = PC (link)
- alu_src_b  out  1  0 = reg B, 1 = extended imm
- alu_op  out  3  0 add, 1 sub, 2 or, 3 slt, 4 lui
- ext_op  out  2  0 zero-ext, 1 sign-ext, 2 upper (imm<<16)
- mem_req  out  1  data memory access active
- mem_write_en  out  1  store
- mem_byte  out  1  byte access (lb/sb)
- halt_sig  out  1  sticky halt
- illegal_inst  out  1  one-cycle pulse in DECODE on unknown opcode/funct
- mem_err  out  1  sticky timeout flag
- state  out  4  debug encoding of current state

Behaviour:
- Reset:
  - Reset is asynchronous, active-high.
  - While reset is high, state = FETCH and every output is 0, including halt_sig and mem_err.
  - The first rising edge after release executes FETCH.
  - Reset mid-instruction aborts it; no partial write occurs after reset deasserts.
- States: FETCH(0), DECODE(1), EXEC_R(2), EXEC_I(3), MEM_ADDR(4), MEM_RD(5), MEM_WR(6), WB_ALU(7), WB_MEM(8), HALT(9).
- Outputs are combinational from state + opcode/funct. Opcode and funct are stable from DECODE onward (IR held).
- FETCH:
  - ir_write_en = 1, pc_write_en = 1, npc_sel = 0.
  - Next state: DECODE.
- DECODE:
  - j: pc_write_en = 1, npc_sel = 2 -> FETCH.
  - jal: same as j, plus reg_write_en = 1, reg_dst = 2, wb_sel = 2 (PC already +4) -> FETCH.
  - jr (SPECIAL, funct 001000): pc_write_en = 1, npc_sel = 3 -> FETCH.
  - beq: alu_op = sub, alu_src_b = 0, ext_op = 1. If zero, pc_write_en = 1, npc_sel = 1. -> FETCH.
  - HLT (111111) -> HALT.
  - Unknown: illegal_inst = 1 -> FETCH (executes as NOP).
  - SPECIAL addu/subu/slt -> EXEC_R; ori/lui/addi/addiu -> EXEC_I; lw/lb/sw/sb -> MEM_ADDR.
- EXEC_R:
  - alu_op: addu = 0, subu = 1, slt = 3; alu_src_b = 0.
  - Next state: WB_ALU.
- EXEC_I:
  - alu_src_b = 1.
  - ori: or, zero-ext. lui: alu_op 4, ext_op 2. addi/addiu: add, sign-ext.
  - Next state: WB_ALU.
- WB_ALU:
  - Controls held from the EXEC state; reg_write_en = 1, wb_sel = 0, reg_dst = 1 for R-type else 0.
  - addi with overflow = 1: reg_write_en = 0.
  - Next state: FETCH.
- MEM_ADDR:
  - add, sign-ext, alu_src_b = 1.
  - Loads -> MEM_RD; stores -> MEM_WR.
- MEM_RD / MEM_WR:
  - mem_req = 1; mem_write_en = 1 in MEM_WR; mem_byte = 1 for lb/sb. Address controls held.
  - All controls stay stable until mem_ready = 1.
  - On mem_ready: MEM_RD -> WB_MEM; MEM_WR -> FETCH.
  - mem_ready in the entry cycle completes immediately (zero wait states).
  - Wait counter (width clog2(MEM_TIMEOUT+1)) clears on entry. If MEM_TIMEOUT > 0 and the count reaches MEM_TIMEOUT: set mem_err, abandon the access (no write, no WB), go to FETCH.
- WB_MEM:
  - reg_write_en = 1, wb_sel = 1, reg_dst = 0.
  - Next state: FETCH.
- HALT:
  - halt_sig = 1; all enables 0.
  - Stays in HALT until reset.
- mem_ready outside MEM_RD/MEM_WR is ignored.
- Latency in cycles (FETCH to next FETCH), zero wait states: j/jal/jr/beq/illegal 2; R-type and I-ALU 4; sw/sb 4; lw/lb 5. Each wait state adds 1.

Decomposition:
- Shared package (mips_defs): OPCODE_* and FUNCT_* constants (existing), plus new NPC_*, WB_*, REGDST_*, ALUOP_*, EXT_* encodings and the state encoding.
- Sub-module mips_mc_decode: purely combinational; maps opcode/funct to an instruction class and per-class ALU/ext controls. The FSM stays in mips_mc_ctrl.

Test Plan:
- Reset pulse mid-MEM_RD (mem_ready held 0) -> all outputs 0 during reset; after release, state = 0 and ir_write_en = 1 next cycle; no reg_write_en seen.
- ori $1,$0,0x1234 then addu $2,$1,$1 -> each takes 4 cycles. In WB_ALU: reg_dst = 0 then 1; alu_op = 2 then 0; reg_write_en = 1.
- lw with mem_ready delayed 3 cycles -> mem_req held for 4 cycles with stable controls; WB_MEM follows; total 8 cycles.
- beq with zero = 1 -> pc_write_en = 1, npc_sel = 1 in DECODE; with zero = 0 -> pc_write_en = 0; both return to FETCH after 2 cycles.
- jal -> in DECODE: reg_dst = 2, wb_sel = 2, npc_sel = 2, reg_write_en = 1. Then addi with overflow = 1 -> reg_write_en = 0 in WB_ALU.
- Opcode 111111 -> halt_sig rises after DECODE and stays 1 for 20 cycles regardless of inputs. Opcode 010101 -> illegal_inst pulses for 1 cycle, then FETCH. With MEM_TIMEOUT = 4 and mem_ready stuck at 0 -> mem_err set after 4 wait cycles, then FETCH.
